ahb_uart_loader: RTL and testbench
==================================

Name: ahb_uart_loader

Overview:
- Single-master AHB-Lite write engine that sits directly upstream of the on-chip AHB code/data BRAM slave.
- Takes a byte stream from the UART receiver and assembles little-endian 32-bit words.
- Writes each word to consecutive word addresses using single NONSEQ word transfers.
- Holds the CPU in reset until a load completes, so program images load at run time instead of from a synthesis-time hex file.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word aligned
LEN_W, 16, width of the word-count input and internal word counter

Ports:
HCLK  input  1  system clock; all logic on rising edge
HRESETn  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a load of len_words words
len_words  input  LEN_W  number of 32-bit words to load; sampled on accepted start
rx_data  input  8  byte from UART receiver
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
HADDR  output  32  AHB address
HTRANS  output  2  AHB transfer type; only 2'b00 IDLE and 2'b10 NONSEQ are used
HWRITE  output  1  AHB write flag
HSIZE  output  3  AHB size; fixed 3'b010 (word) during transfers
HWDATA  output  32  AHB write data
HREADY  input  1  AHB transfer-complete / ready from interconnect
HRESP  input  1  AHB error response
busy  output  1  load in progress
done  output  1  last load completed without error; level
err  output  1  last load aborted on HRESP; level
cpu_hold  output  1  active-high hold for the CPU reset
checksum  output  32  mod-2^32 sum of all words written in the current/last load

Behaviour:
- Reset (HRESETn=0 at a clock edge) → state IDLE and the following outputs:
  - HTRANS=00, HWRITE=0, HSIZE=010, HADDR=BASE_ADDR, HWDATA=0;
  - rx_ready=0, busy=0, done=0, err=0, cpu_hold=1, checksum=0.
  - Reset mid-load abandons the load; any partially written memory is left as is.
- All outputs decode from registered state only. There is no combinational path from inputs to outputs.
- State IDLE:
  - start=1 latches len_words, clears the word counter, byte index, checksum, done and err, and sets busy=1 and cpu_hold=1.
  - Then goes to COLLECT, or to DONE in the same step if len_words=0.
- State COLLECT:
  - rx_ready=1. A byte is accepted when rx_valid & rx_ready.
  - Byte k (k=0..3) is written into word bits [8k+7:8k], so the first byte received is the LSB.
  - After the 4th byte → ADDR. rx_ready=0 in every other state.
- State ADDR (address phase):
  - HTRANS=10, HWRITE=1, HSIZE=010, HADDR=BASE_ADDR + 4*word_count (32-bit wrap).
  - Held until a clock edge with HREADY=1, then → DATA.
- State DATA (data phase):
  - HTRANS=00, HWRITE=0, HWDATA=assembled word, held stable until a clock edge with HREADY=1.
  - On that edge with HRESP=0: checksum += word, word_count += 1, then → DONE if word_count reaches len_words, else → COLLECT.
  - On that edge with HRESP=1 → ERR. The word is not counted and not added to the checksum.
  - HRESP is ignored while HREADY=0 (first cycle of the two-cycle ERROR response).
- State DONE: busy=0, done=1, cpu_hold=0 → IDLE.
- State ERR: busy=0, err=1, cpu_hold stays 1 → IDLE.
- Result levels: done, err and cpu_hold keep their values in IDLE until the next accepted start.
- start is ignored while busy=1.
- No address-phase pipelining: a new address phase never overlaps the previous data phase.
- HADDR stays at the last address driven while idle.
- word_count is LEN_W bits wide and never wraps, since it stops at len_words. The address computation wraps modulo 2^32.

Test Plan:
- Zero-wait load: start with len_words=2, bytes 78 56 34 12 EF BE AD DE.
  - Expect: NONSEQ to 0x0 with HWDATA=0x12345678, then NONSEQ to 0x4 with HWDATA=0xDEADBEEF; each data phase immediately follows its address phase.
  - Expect: checksum=0xF0E21567; done=1 and cpu_hold=0 one cycle after the last data phase.
- Wait states: HREADY=0 for 3 cycles in the address phase and 2 cycles in the data phase.
  - Expect: HADDR, HTRANS and HWDATA held stable throughout; word_count advances exactly once; the result is identical to the zero-wait case.
- Byte-stream stalls: rx_valid toggles 1,0,0,1,...
  - Expect: a byte is consumed only on cycles with rx_valid & rx_ready; no bytes are duplicated or dropped; the assembled word is correct.
- Error response: HRESP=1 with HREADY=0 then HRESP=1 with HREADY=1 on the 2nd word.
  - Expect: err=1, done=0, cpu_hold=1, checksum equals word 0 only, HTRANS=00 afterwards.
- Edge cases:
  - len_words=0 → done=1 with no AHB transfer and no rx_ready.
  - start while busy → no effect.
  - HRESETn=0 during ADDR → next cycle HTRANS=00, busy=0, cpu_hold=1.

Source files
------------

// File: rtl/ahb_uart_loader.sv
// AHB-Lite single-master loader: packs UART bytes into little-endian words and
// writes them to consecutive word addresses, holding the CPU in reset until done.
module ahb_uart_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LEN_W     = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cpu_hold,
  output logic [31:0]      checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       bidx_q, bidx_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      haddr_q, haddr_d;
  logic [31:0]      csum_q, csum_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             hold_q, hold_d;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      bidx_q  <= 2'd0;
      word_q  <= 32'd0;
      haddr_q <= BASE_ADDR;
      csum_q  <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      haddr_q <= haddr_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    haddr_d = haddr_q;
    csum_d  = csum_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d  = len_words;
          cnt_d  = '0;
          bidx_d = 2'd0;
          csum_d = 32'd0;
          done_d = 1'b0;
          err_d  = 1'b0;
          hold_d = 1'b1;
          if (len_words == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        // rx_ready is high throughout this state, so rx_valid alone means a handshake
        if (rx_valid) begin
          word_d[{bidx_q, 3'b000} +: 8] = rx_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d = S_ADDR;
            haddr_d = BASE_ADDR + (32'(cnt_q) << 2);
          end
        end
      end
      S_ADDR: begin
        if (HREADY) state_d = S_DATA;
      end
      S_DATA: begin
        // HRESP only counts on the completing edge of a two-cycle error response
        if (HREADY) begin
          if (HRESP) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            csum_d = csum_q + word_q;
            cnt_d  = cnt_q + LEN_W'(1);
            if (cnt_q + LEN_W'(1) == len_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
            end else begin
              state_d = S_COLLECT;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_ready = (state_q == S_COLLECT);
  assign HTRANS   = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign HWRITE   = (state_q == S_ADDR);
  assign HSIZE    = 3'b010;
  assign HADDR    = haddr_q;
  assign HWDATA   = word_q;
  assign busy     = (state_q == S_COLLECT) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = hold_q;
  assign checksum = csum_q;

endmodule

// File: tb/tb_ahb_uart_loader.sv
// Directed bench for ahb_uart_loader: bench plays UART source and AHB slave.
module tb_ahb_uart_loader;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start;
  logic [15:0] len_words;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;
  logic [31:0] checksum;

  int n_chk  = 0;
  int n_fail = 0;

  ahb_uart_loader #(.BASE_ADDR(32'h0000_0000), .LEN_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .len_words(len_words),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold), .checksum(checksum)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Gap cycles present junk with rx_valid low so a spurious accept corrupts the word.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    rx_data  = 8'h5A;
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("rx_ready_during_gap", {31'd0, rx_ready}, 32'd1);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h5A;
  endtask

  task automatic do_word(input logic [31:0] w, input logic [31:0] addr, input int gap,
                         input int aw, input int dw, input logic resp);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    chk("addr_htrans", {30'd0, HTRANS}, 32'd2);
    chk("addr_haddr", HADDR, addr);
    chk("addr_hwrite", {31'd0, HWRITE}, 32'd1);
    chk("addr_hsize", {29'd0, HSIZE}, 32'd2);
    chk("addr_rx_ready", {31'd0, rx_ready}, 32'd0);
    HREADY = 1'b0;
    for (int i = 0; i < aw; i++) begin
      tick();
      chk("addr_wait_htrans", {30'd0, HTRANS}, 32'd2);
      chk("addr_wait_haddr", HADDR, addr);
    end
    HREADY = 1'b1;
    tick();
    chk("data_htrans", {30'd0, HTRANS}, 32'd0);
    chk("data_hwrite", {31'd0, HWRITE}, 32'd0);
    chk("data_hwdata", HWDATA, w);
    HREADY = 1'b0;
    HRESP  = resp;
    for (int i = 0; i < dw; i++) begin
      tick();
      chk("data_wait_hwdata", HWDATA, w);
      chk("data_wait_htrans", {30'd0, HTRANS}, 32'd0);
      chk("data_wait_busy", {31'd0, busy}, 32'd1);
    end
    HREADY = 1'b1;
    HRESP  = resp;
    tick();
    HRESP = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] len);
    start     = 1'b1;
    len_words = len;
    tick();
    start     = 1'b0;
    len_words = 16'd0;
  endtask

  initial begin
    HRESETn   = 1'b0;
    start     = 1'b0;
    len_words = 16'd0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
    chk("rst_hsize", {29'd0, HSIZE}, 32'd2);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_checksum", checksum, 32'h0);
    HRESETn = 1'b1;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Zero-wait load of two words
    do_start(16'd2);
    chk("zw_busy", {31'd0, busy}, 32'd1);
    chk("zw_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("zw_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    do_word(32'h1234_5678, 32'h0, 0, 0, 0, 1'b0);
    chk("zw_mid_checksum", checksum, 32'h1234_5678);
    chk("zw_mid_rx_ready", {31'd0, rx_ready}, 32'd1);
    do_word(32'hDEAD_BEEF, 32'h4, 0, 0, 0, 1'b0);
    chk("zw_done", {31'd0, done}, 32'd1);
    chk("zw_cpu_hold_rel", {31'd0, cpu_hold}, 32'd0);
    chk("zw_busy_end", {31'd0, busy}, 32'd0);
    chk("zw_checksum", checksum, 32'hF0E2_1567);
    tick();
    chk("zw_idle_done", {31'd0, done}, 32'd1);
    chk("zw_idle_hold", {31'd0, cpu_hold}, 32'd0);
    chk("zw_idle_haddr", HADDR, 32'h4);
    chk("zw_idle_htrans", {30'd0, HTRANS}, 32'd0);

    // Wait states, byte stalls, and a start pulse while busy
    do_start(16'd2);
    chk("ws_done_cleared", {31'd0, done}, 32'd0);
    chk("ws_hold_set", {31'd0, cpu_hold}, 32'd1);
    do_word(32'h1234_5678, 32'h0, 2, 3, 2, 1'b0);
    chk("ws_mid_checksum", checksum, 32'h1234_5678);
    do_start(16'd0);
    chk("busy_start_busy", {31'd0, busy}, 32'd1);
    chk("busy_start_done", {31'd0, done}, 32'd0);
    chk("busy_start_rx_ready", {31'd0, rx_ready}, 32'd1);
    do_word(32'hDEAD_BEEF, 32'h4, 2, 3, 2, 1'b0);
    chk("ws_done", {31'd0, done}, 32'd1);
    chk("ws_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("ws_checksum", checksum, 32'hF0E2_1567);
    tick();

    // Error response on the second word
    do_start(16'd2);
    chk("er_done_cleared", {31'd0, done}, 32'd0);
    do_word(32'h4433_2211, 32'h0, 0, 0, 0, 1'b0);
    do_word(32'hDDCC_BBAA, 32'h4, 0, 0, 1, 1'b1);
    chk("er_err", {31'd0, err}, 32'd1);
    chk("er_done", {31'd0, done}, 32'd0);
    chk("er_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("er_busy", {31'd0, busy}, 32'd0);
    chk("er_checksum", checksum, 32'h4433_2211);
    chk("er_htrans", {30'd0, HTRANS}, 32'd0);
    tick();
    chk("er_idle_err", {31'd0, err}, 32'd1);
    chk("er_idle_hold", {31'd0, cpu_hold}, 32'd1);
    chk("er_idle_htrans", {30'd0, HTRANS}, 32'd0);

    // Zero-length load
    do_start(16'd0);
    chk("z_done", {31'd0, done}, 32'd1);
    chk("z_err", {31'd0, err}, 32'd0);
    chk("z_busy", {31'd0, busy}, 32'd0);
    chk("z_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("z_htrans", {30'd0, HTRANS}, 32'd0);
    chk("z_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("z_checksum", checksum, 32'h0);
    tick();
    chk("z_idle_done", {31'd0, done}, 32'd1);
    chk("z_idle_htrans", {30'd0, HTRANS}, 32'd0);

    // Reset during the address phase
    do_start(16'd1);
    for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k), 0);
    HREADY = 1'b0;
    chk("ra_htrans_before", {30'd0, HTRANS}, 32'd2);
    HRESETn = 1'b0;
    tick();
    chk("ra_htrans", {30'd0, HTRANS}, 32'd0);
    chk("ra_busy", {31'd0, busy}, 32'd0);
    chk("ra_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("ra_done", {31'd0, done}, 32'd0);
    chk("ra_hwdata", HWDATA, 32'h0);
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    tick();
    chk("ra_idle_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
